// File: rtl/shared_debounce_arbiter_pkg.sv
// shared_debounce_arbiter_pkg: shared constants, FSM state type and index-width helper
package shared_debounce_arbiter_pkg;

    localparam int DEBOUNCE_WAIT_BITS_27MHZ = 18;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_debounce_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr, circularly
module rr_pick
    import shared_debounce_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_grant,
    output logic         o_valid
);

    logic [W-1:0] w_idx;

    // scan from the farthest offset down so the nearest request to ptr wins
    always_comb begin
        o_grant = '0;
        o_valid = |i_req;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) o_grant = w_idx;
        end
    end

endmodule

// File: rtl/shared_debounce_arbiter.sv
// shared_debounce_arbiter: N-button debouncer sharing one lockout timer via round-robin grants
module shared_debounce_arbiter
    import shared_debounce_arbiter_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int WAIT_BITS   = DEBOUNCE_WAIT_BITS_27MHZ,
    parameter int SYNC_STAGES = 2,
    localparam int IW         = idx_w(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             busy,
    output logic [IW-1:0]    grant_idx
);

    logic [SYNC_STAGES-1:0][N_BTN-1:0] r_sync;
    logic [N_BTN-1:0]                  r_level, r_press, r_release;
    logic [IW-1:0]                     r_grant, r_ptr;
    logic [WAIT_BITS-1:0]              r_timer;
    logic                              r_busy;
    state_t                            r_state, w_next;
    logic [N_BTN-1:0]                  w_sync, w_pending;
    logic [IW-1:0]                     w_grant;
    logic                              w_valid, w_commit, w_done;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_pending = w_sync ^ r_level;

    rr_pick #(.N(N_BTN), .W(IW)) u_pick (
        .i_req   (w_pending),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // raw inputs are asynchronous, so shift them through a synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // commit a pending button from IDLE; leave HOLD when the lockout timer tops out
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        w_done   = 1'b0;
        if (r_state == IDLE && w_valid) begin
            w_commit = 1'b1;
            w_next   = HOLD;
        end else if (r_state == HOLD && &r_timer) begin
            w_done = 1'b1;
            w_next = IDLE;
        end
    end

    // levels, pulses, lockout timer and round-robin pointer; levels only move on a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_timer   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            if (w_commit) begin
                r_level[w_grant]   <= w_sync[w_grant];
                r_press[w_grant]   <= w_sync[w_grant];
                r_release[w_grant] <= ~w_sync[w_grant];
                r_grant            <= w_grant;
                r_timer            <= WAIT_BITS'(1);
                r_busy             <= 1'b1;
            end else if (w_done) begin
                r_timer <= '0;
                r_busy  <= 1'b0;
                r_ptr   <= (r_grant == IW'(N_BTN - 1)) ? '0 : r_grant + 1'b1;
            end else if (r_state == HOLD) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign busy        = r_busy;
    assign grant_idx   = r_grant;

endmodule
